// File: rtl/fetch_pc_gen_if.sv
// Fetch front-end bundle: redirect, I-cache request/response and decode-side
// instruction hand-off. The fetch unit takes the master side.
interface fetch_pc_gen_if #(
    parameter int WIDTH = 32
);
    logic             redirect_valid;
    logic [WIDTH-1:0] redirect_pc;
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_pc;
    logic             req_fire;
    logic             resp_valid;
    logic [WIDTH-1:0] resp_inst;
    logic             inst_valid;
    logic [WIDTH-1:0] inst;
    logic [WIDTH-1:0] inst_pc;
    logic             decode_ready;

    modport master (
        input  redirect_valid, redirect_pc, req_ready, resp_valid, resp_inst, decode_ready,
        output req_valid, req_pc, req_fire, inst_valid, inst, inst_pc
    );

    modport slave (
        output redirect_valid, redirect_pc, req_ready, resp_valid, resp_inst, decode_ready,
        input  req_valid, req_pc, req_fire, inst_valid, inst, inst_pc
    );
endinterface

// File: rtl/fetch_pc_gen.sv
// Next-PC generator and single-outstanding I-cache fetch controller with a
// one-entry instruction register toward decode and stale-response killing.
module fetch_pc_gen #(
    parameter int               WIDTH  = 32,
    parameter logic [WIDTH-1:0] PC_RST = WIDTH'(32'h1c00_0000)
) (
    input  logic           clk,
    input  logic           rst,
    fetch_pc_gen_if.master bus
);
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_KILL = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] inflight_pc;
    logic             inst_valid_q;
    logic [WIDTH-1:0] inst_q;
    logic [WIDTH-1:0] inst_pc_q;

    logic             buf_free;
    logic             req_valid;
    logic             req_fire;
    logic             load;
    logic [WIDTH-1:0] redirect_tgt;

    assign buf_free     = !inst_valid_q || bus.decode_ready;
    // req_valid deliberately excludes req_ready so the cache can depend on it.
    assign req_valid    = (state == S_REQ) && !bus.redirect_valid && buf_free;
    assign req_fire     = req_valid && bus.req_ready;
    assign load         = (state == S_WAIT) && bus.resp_valid && !bus.redirect_valid;
    assign redirect_tgt = bus.redirect_pc & ALIGN_MASK;

    assign bus.req_valid  = req_valid;
    assign bus.req_fire   = req_fire;
    assign bus.req_pc     = pc;
    assign bus.inst_valid = inst_valid_q;
    assign bus.inst       = inst_q;
    assign bus.inst_pc    = inst_pc_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_REQ;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: next state gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            S_REQ: begin
                if (req_fire) state_next = S_WAIT;
            end
            S_WAIT: begin
                if (bus.resp_valid)          state_next = S_REQ;
                else if (bus.redirect_valid) state_next = S_KILL;
            end
            S_KILL: begin
                if (bus.resp_valid) state_next = S_REQ;
            end
            default: state_next = S_REQ;
        endcase
    end

    // Redirect outranks everything: it reloads the PC and flushes the output.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc           <= PC_RST & ALIGN_MASK;
            inflight_pc  <= '0;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
        end else begin
            if (bus.redirect_valid) begin
                pc <= redirect_tgt;
            end else if (req_fire) begin
                pc <= pc + WIDTH'(4);
            end

            if (req_fire) begin
                inflight_pc <= pc;
            end

            if (bus.redirect_valid) begin
                inst_valid_q <= 1'b0;
            end else if (load) begin
                inst_valid_q <= 1'b1;
            end else if (bus.decode_ready) begin
                inst_valid_q <= 1'b0;
            end

            if (load) begin
                inst_q    <= bus.resp_inst;
                inst_pc_q <= inflight_pc;
            end
        end
    end
endmodule

// File: doc/fetch_pc_gen.md
# fetch_pc_gen

Next-PC generator and fetch request controller for the instruction-fetch front end. Holds the architectural fetch PC, issues one instruction-cache request at a time over a valid/ready handshake, and supplies the address and write enable that load the downstream request buffer. Collects the cache response into a one-entry output register toward decode, and discards responses made stale by a branch or exception redirect.

## Interface
- `WIDTH`, 32, address/instruction width
- `PC_RST`, 32'h1c00_0000, fetch PC after reset

- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  synchronous, active-low reset
- `redirect_valid`  in  1  branch/exception redirect this cycle
- `redirect_pc`  in  WIDTH  redirect target; bits [1:0] ignored and forced to 0
- `req_valid`  out  1  fetch request to I-cache
- `req_ready`  in  1  I-cache accepts request
- `req_pc`  out  WIDTH  request address; also drives the request buffer data input
- `req_fire`  out  1  `req_valid & req_ready`; drives the request buffer write enable
- `resp_valid`  in  1  I-cache returns instruction (one-cycle pulse)
- `resp_inst`  in  WIDTH  returned instruction word
- `inst_valid`  out  1  output register holds an instruction for decode
- `inst`  out  WIDTH  instruction to decode
- `inst_pc`  out  WIDTH  PC of `inst`
- `decode_ready`  in  1  decode consumes `inst` this cycle when `inst_valid`

## Operation
- Registers: `pc`, `inflight_pc`, `state`, `inst_valid`, `inst`, `inst_pc`.
- The output buffer is free when `!inst_valid || decode_ready`.
- States:
  - REQ: `req_valid = !redirect_valid && buffer free`. On `req_fire`, `inflight_pc <= pc`, `pc <= pc + 4`, go to WAIT.
  - WAIT: one request is outstanding. On `resp_valid` with no redirect, `inst <= resp_inst`, `inst_pc <= inflight_pc`, `inst_valid <= 1`, go to REQ.
  - KILL: the outstanding request has been cancelled. On `resp_valid`, drop the response and go to REQ.
- Redirect has the highest priority, in every state:
  - `pc <= {redirect_pc[WIDTH-1:2], 2'b00}` and `inst_valid <= 0`.
  - REQ: no request is issued that cycle; stay in REQ.
  - WAIT: go to KILL. If `resp_valid` arrives in the same cycle, drop it and go to REQ.
  - KILL: stay in KILL, or go to REQ if `resp_valid` arrives in the same cycle.
- Decode consumption: `inst_valid <= 0` when `decode_ready` and no new response is being loaded. A response load and a consume in the same cycle leave `inst_valid` at 1.
- Because a request issues only when the buffer is free, the buffer is always free when the response arrives. A response must never be dropped except in KILL or on redirect.
- `pc + 4` wraps modulo 2^WIDTH. `req_pc[1:0]` is always 0.
- Reset (`rst == 0` at a rising edge) forces:
  - `pc = PC_RST`, `state = REQ`
  - `inst_valid = 0`, `inst = 0`, `inst_pc = 0`, `inflight_pc = 0`
  
  Reset mid-transaction abandons the in-flight request. The I-cache shares this reset, so no stale response follows.

## Timing
- `req_valid`, `req_pc` and `req_fire` are combinational from state and registers plus `redirect_valid`/`decode_ready`. `req_valid` must not depend on `req_ready`.
- First request: `req_valid = 1` with `req_pc = PC_RST` in the first cycle after `rst` deasserts.
- Latency: a `resp_valid` in cycle t gives `inst_valid = 1` in cycle t+1. The next request can fire in cycle t+1.
- Peak throughput: one instruction per 2 cycles when the cache answers in the cycle after `req_fire`.
- Redirect in cycle t: `req_pc = redirect target` in cycle t+1. `inst_valid = 0` in cycle t+1.
- `req_ready` low holds REQ with `req_pc` stable. Requests may not be withdrawn except by redirect or a full output buffer.

## Test plan
- Reset then cache answers every next cycle, `decode_ready = 1`:
  - `req_pc` = 1c000000, 1c000004, 1c000008 on fire cycles.
  - `inst_pc` follows the same sequence, one cycle after each response.
- `req_ready = 0` for 3 cycles after reset:
  - `req_valid` stays high with `req_pc = 1c000000` throughout.
  - `req_fire` only in cycle 4.
- Redirect to 0x1c000100 while in WAIT, response arrives 2 cycles later:
  - The response is dropped and `inst_valid` stays 0.
  - The next `req_pc` is 1c000100.
- Redirect to 0x1c000203 in the same cycle as `resp_valid`: no instruction is delivered, and the next `req_pc` is 1c000200.
- `decode_ready = 0` with `inst_valid = 1`:
  - No `req_fire` occurs, and `inst`/`inst_pc` stay stable.
  - Raise `decode_ready`: a request fires in that same cycle.
- Reset asserted while in WAIT, then released: `inst_valid = 0` and `req_pc = 1c000000`. PC wrap: redirect to 0xfffffffc gives next `req_pc` 0x00000000 after fire.
